// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, FSM encoding and operand-sign helpers for the M-extension unit.
package ex_muldiv_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a {hi, lo} pair.
// Multiply: {hi, lo} is the product accumulator, lo holds the remaining multiplier bits.
// Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
module ex_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic          ge;

    // Compute one step of whichever operation is selected.
    always_comb begin
        sum     = '0;
        rem_sh  = '0;
        ge      = 1'b0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Partial remainder stays below the divisor, so XLEN+1 bits hold the shifted value.
            rem_sh  = {hi, lo[XLEN-1]};
            ge      = rem_sh >= {1'b0, operand};
            hi_next = ge ? (rem_sh[XLEN-1:0] - operand) : rem_sh[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ge};
        end else begin
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with stall request and flush.
//   state | meaning
//   IDLE  | waiting for start_i; captures operands on accept
//   CALC  | iterating, BPC bits per cycle, N cycles
//   DONE  | result valid on done_o / wdata_o for one cycle
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stallreq_o,
    output logic            done_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);

    localparam int N     = XLEN / BPC;
    localparam int CNT_W = $clog2(N);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
    logic [2:0]        op_q;
    logic              sign1_q, sign2_q;

    logic              accept, special, div_zero, overflow, last_iter;
    logic              s1_in, s2_in;
    logic [XLEN-1:0]   abs1, abs2, special_res, calc_res, int_min;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   hi_c [BPC+1];
    logic [XLEN-1:0]   lo_c [BPC+1];

    assign int_min = {1'b1, {(XLEN-1){1'b0}}};

    // Decode the incoming request: signs, magnitudes and the divide special cases.
    always_comb begin
        s1_in       = reg1_i[XLEN-1] & rs1_signed(op_i);
        s2_in       = reg2_i[XLEN-1] & rs2_signed(op_i);
        abs1        = s1_in ? -reg1_i : reg1_i;
        abs2        = s2_in ? -reg2_i : reg2_i;
        div_zero    = op_is_div(op_i) && (reg2_i == '0);
        overflow    = ((op_i == OP_DIV) || (op_i == OP_REM)) && (reg1_i == int_min) && (reg2_i == '1);
        special     = div_zero || overflow;
        // op_i[1] selects remainder among the divide ops.
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? reg1_i : '1;
        else if (overflow)
            special_res = op_i[1] ? '0 : reg1_i;
        accept      = (state_q == ST_IDLE) && start_i && !flush_i;
        last_iter   = (state_q == ST_CALC) && (cnt_q == '0);
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < BPC; g++) begin : g_step
        ex_muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_is_div(op_q)),
            .operand (opnd_q),
            .hi      (hi_c[g]),
            .lo      (lo_c[g]),
            .hi_next (hi_c[g+1]),
            .lo_next (lo_c[g+1])
        );
    end

    // Sign fix-up and result selection from the output of the final step.
    always_comb begin
        prod     = {hi_c[BPC], lo_c[BPC]};
        prod_fix = (sign1_q ^ sign2_q) ? -prod : prod;
        quot_fix = (sign1_q ^ sign2_q) ? -lo_c[BPC] : lo_c[BPC];
        rem_fix  = sign1_q ? -hi_c[BPC] : hi_c[BPC];
        calc_res = '0;
        case (op_q)
            OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              calc_res = quot_fix;
            OP_REM, OP_REMU:              calc_res = rem_fix;
            default:                      calc_res = '0;
        endcase
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i)
            state_d = ST_IDLE;
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign stallreq_o = accept || (state_q == ST_CALC);
    assign wreg_o     = done_o;

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Operand capture on accept, then one BPC-wide iteration per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= CNT_W'(N - 1);
            hi_q    <= '0;
            lo_q    <= op_is_div(op_i) ? abs1 : abs2;
            opnd_q  <= op_is_div(op_i) ? abs2 : abs1;
            op_q    <= op_i;
            sign1_q <= s1_in;
            sign2_q <= s2_in;
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q - 1'b1;
            hi_q  <= hi_c[BPC];
            lo_q  <= lo_c[BPC];
        end
    end

    // Registered result outputs; the done pulse is dropped on flush.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            done_o  <= 1'b0;
            wdata_o <= '0;
            wd_o    <= '0;
        end else begin
            done_o  <= 1'b0;
            wdata_o <= '0;
            if (accept)
                wd_o <= wd_i;
            if (!flush_i) begin
                if (accept && special) begin
                    done_o  <= 1'b1;
                    wdata_o <= special_res;
                end else if (last_iter) begin
                    done_o  <= 1'b1;
                    wdata_o <= calc_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one BPC=1 and one BPC=4 instance share the same stimulus.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        flush_i;

    logic        busy1, stall1, done1, wreg1;
    logic [31:0] wdata1;
    logic [4:0]  wd1;
    logic        busy4, stall4, done4, wreg4;
    logic [31:0] wdata4;
    logic [4:0]  wd4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .flush_i(flush_i), .busy_o(busy1), .stallreq_o(stall1), .done_o(done1),
        .wdata_o(wdata1), .wd_o(wd1), .wreg_o(wreg1)
    );

    ex_muldiv #(.XLEN(32), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .flush_i(flush_i), .busy_o(busy4), .stallreq_o(stall4), .done_o(done4),
        .wdata_o(wdata4), .wd_o(wd4), .wreg_o(wreg4)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request (caller is #1 after an edge) and check both instances.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input logic [31:0] exp,
                          input bit is_special);
        int lat1, lat4;
        logic [31:0] r1, r4;
        logic [4:0]  w1, w4;
        logic        g1, g4, st1, st4;
        lat1 = -1; lat4 = -1;
        r1 = '0; r4 = '0; w1 = '0; w4 = '0; g1 = 0; g4 = 0; st1 = 1; st4 = 1;
        start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b; wd_i = wd;
        #1;
        check_val({name, " stall_req"}, 64'(stall1 & stall4), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0; reg1_i = '0; reg2_i = '0; wd_i = '0;
        for (int j = 0; j <= 40; j++) begin
            if (lat1 < 0 && done1) begin lat1 = j; r1 = wdata1; w1 = wd1; g1 = wreg1; st1 = stall1; end
            if (lat4 < 0 && done4) begin lat4 = j; r4 = wdata4; w4 = wd4; g4 = wreg4; st4 = stall4; end
            if (lat1 >= 0 && lat4 >= 0) break;
            @(posedge clk); #1;
        end
        check_val({name, " lat1"},   64'(lat1), is_special ? 64'd0 : 64'd32);
        check_val({name, " lat4"},   64'(lat4), is_special ? 64'd0 : 64'd8);
        check_val({name, " data1"},  64'(r1), 64'(exp));
        check_val({name, " data4"},  64'(r4), 64'(exp));
        check_val({name, " wd"},     64'({w1, w4}), 64'({wd, wd}));
        check_val({name, " wreg"},   64'({g1, g4}), 64'b11);
        check_val({name, " stall_done"}, 64'({st1, st4}), 64'b00);
        @(posedge clk); #1;
        check_val({name, " pulse_end"}, 64'({done1, busy1}), 64'b00);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start_i = 1'b0; op_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outs", 64'({busy1, stall1, done1, wreg1, wdata1, wd1}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 0);
        run_op("mul_lo", 3'd0, 32'h12345678, 32'h00000010, 5'd9,  32'h23456780, 0);
        run_op("mulhu2", 3'd3, 32'h12345678, 32'h00000010, 5'd10, 32'h00000001, 0);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 0);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 0);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd13, 32'd14,       0);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd14, 32'd2,        0);
        run_op("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,      0);
        run_op("divu_z", 3'd5, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1);
        run_op("rem_z",  3'd6, 32'd5,        32'd0,        5'd17, 32'd5,        1);
        run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
        run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1);

        // Flush in the middle of a BPC=1 divide.
        start_i = 1'b1; op_i = 3'd5; reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd20;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        check_val("flush_stall_before", 64'(stall1), 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check_val("flush_idle", 64'({busy1, stall1, done1, wreg1}), 64'd0);
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done1 || stall1) pulses++;
        end
        check_val("flush_no_done", 64'(pulses), 64'd0);
        run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd21, 32'd14, 0);

        // Start together with flush in IDLE is not accepted.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd3; wd_i = 5'd22;
        #1;
        check_val("flush_start_stall", 64'({stall1, stall4}), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        check_val("flush_start_busy", 64'({busy1, busy4, done1, done4}), 64'd0);

        // Reset in the middle of a multiply.
        start_i = 1'b1; op_i = 3'd0; reg1_i = 32'd7; reg2_i = 32'hFFFFFFFD; wd_i = 5'd23;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("pre_rst_busy", 64'({busy1, busy4}), 64'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_outs1", 64'({busy1, stall1, done1, wreg1, wdata1, wd1}), 64'd0);
        check_val("rst_mid_outs4", 64'({busy4, stall4, done4, wreg4, wdata4, wd4}), 64'd0);
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done1 || done4) pulses++;
        end
        check_val("rst_no_done", 64'(pulses), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
